// File: rtl/tdm_demux8_16_pkg.sv
// Shared constants, state encoding and slot decode for the TDM demultiplexer.
package tdm_demux8_16_pkg;

  localparam int unsigned TDM_SLOTS = 8;
  localparam int unsigned SLOT_BITS = 3;
  localparam logic [7:0]  ERR_MAX   = 8'd255;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  // 1-of-8 demux of the enable onto the addressed slot.
  function automatic logic [TDM_SLOTS-1:0] slot_onehot(input logic [SLOT_BITS-1:0] sel,
                                                        input logic                 en);
    slot_onehot = en ? (TDM_SLOTS'(1) << sel) : '0;
  endfunction

endpackage

// File: rtl/tdm_demux8_16.sv
// Receive end of the 8-slot TDM link: hunts for slot 0, gathers a frame in shadow
// registers and commits all eight channels at once on the slot-7 edge.
module tdm_demux8_16
  import tdm_demux8_16_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [7:0]       err_count
);

  state_e                 r_state;
  state_e                 w_state_d;
  logic [SLOT_BITS-1:0]   r_slot;
  logic [SLOT_BITS-1:0]   w_slot_d;
  logic [WIDTH-1:0]       r_shadow [TDM_SLOTS-1];
  logic [TDM_SLOTS-1:0]   w_we;
  logic                   w_sof;
  logic                   w_commit;
  logic                   w_resync;

  assign w_sof    = in_valid & in_sof;
  // Data-slot enables; slot 0 is only ever loaded by a sof word.
  assign w_we     = slot_onehot(r_slot, (r_state == RECV) & in_valid & ~in_sof);
  assign w_commit = w_we[TDM_SLOTS-1];

  always_comb begin
    w_state_d = r_state;
    w_slot_d  = r_slot;
    w_resync  = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_sof) begin
          w_state_d = RECV;
          w_slot_d  = SLOT_BITS'(1);
        end
      end
      RECV: begin
        if (w_sof) begin
          w_resync = 1'b1;
          w_slot_d = SLOT_BITS'(1);
        end else if (w_commit) begin
          w_state_d = HUNT;
          w_slot_d  = '0;
        end else if (in_valid) begin
          w_slot_d = r_slot + SLOT_BITS'(1);
        end
      end
      default: begin
        w_state_d = HUNT;
        w_slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_d;
      r_slot  <= w_slot_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TDM_SLOTS - 1; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < TDM_SLOTS - 1; i++) begin
        if (w_we[i] || (i == 0 && w_sof)) r_shadow[i] <= in;
      end
    end
  end

  // Slot 7 bypasses the shadow bank and lands in h on the committing edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
      d <= '0;
      e <= '0;
      f <= '0;
      g <= '0;
      h <= '0;
    end else if (w_commit) begin
      a <= r_shadow[0];
      b <= r_shadow[1];
      c <= r_shadow[2];
      d <= r_shadow[3];
      e <= r_shadow[4];
      f <= r_shadow[5];
      g <= r_shadow[6];
      h <= in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= w_commit;
      frame_err   <= w_resync;
      if (w_resync && err_count != ERR_MAX) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdm_demux8_16.sv
// Directed plus randomized bench; a queue-based frame model predicts every output.
module tb_tdm_demux8_16;

  logic        clock;
  logic        reset_n;
  logic [15:0] in;
  logic        in_valid;
  logic        in_sof;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  err_count;

  logic [15:0] dut_out [8];
  assign dut_out[0] = a;
  assign dut_out[1] = b;
  assign dut_out[2] = c;
  assign dut_out[3] = d;
  assign dut_out[4] = e;
  assign dut_out[5] = f;
  assign dut_out[6] = g;
  assign dut_out[7] = h;

  tdm_demux8_16 #(.WIDTH(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in         (in),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: words of the frame in progress (empty = hunting), last committed frame.
  logic [15:0] m_q [$];
  logic [15:0] m_out [8];
  int          m_err;
  bit          m_fv;
  bit          m_fe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) check($sformatf("out_%0d", i), 32'(dut_out[i]), 32'(m_out[i]));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    check("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 8; i++) m_out[i] = '0;
    m_err = 0;
    m_fv  = 0;
    m_fe  = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [15:0] w);
    m_fv = 0;
    m_fe = 0;
    if (v) begin
      if (s) begin
        if (m_q.size() != 0) begin
          m_fe = 1;
          if (m_err < 255) m_err++;
        end
        m_q.delete();
        m_q.push_back(w);
      end else if (m_q.size() != 0) begin
        m_q.push_back(w);
        if (m_q.size() == 8) begin
          for (int i = 0; i < 8; i++) m_out[i] = m_q[i];
          m_q.delete();
          m_fv = 1;
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] w);
    in_valid = v;
    in_sof   = s;
    in       = w;
    @(posedge clock);
    #1;
    model_step(v, s, w);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  task automatic send_frame(input logic [15:0] base, input int max_gap);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k == 0, base + 16'(k));
      if (max_gap > 0 && k < 7) idle($urandom_range(1, max_gap));
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in       = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    check_all();

    send_frame(16'h1000, 0);
    idle(2);
    send_frame(16'h1000, 3);
    idle(1);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'hDEAD);
    send_frame(16'h2000, 0);

    drive(1'b1, 1'b1, 16'h4000);
    for (int i = 1; i < 4; i++) drive(1'b1, 1'b0, 16'h4000 + 16'(i));
    send_frame(16'h3000, 0);
    check("err_after_resync", 32'(err_count), 32'd1);

    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 16'h5000 + 16'(k));
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h5005 + 16'(i));
    send_frame(16'h6000, 2);

    for (int i = 0; i < 250; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 16'($urandom));
    idle(1);

    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 16'($urandom));
      drive(1'b1, 1'b0, 16'($urandom));
    end
    check("err_saturated", 32'(err_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
